// File: rtl/ifetch_buffer_pkg.sv
// Shared types and helpers for the instruction fetch buffer.
// Optional macro IFETCH_MISALIGN_CHECK_EN adds a per-slot misalign flag.
package ifetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Per-slot control bits; pc/data words live in XLEN-parameterised arrays.
  typedef struct packed {
    logic filled;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic misalign;
`endif
  } slot_flags_t;

  // Pointers carry one extra wrap bit so full and empty differ.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// PC-unit, instruction-memory and decode handshakes of ifetch_buffer.
// Optional macro IFETCH_MISALIGN_CHECK_EN adds instr_misalign.
interface ifetch_buffer_if
  import ifetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) ();

  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_data;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic            instr_misalign;
`endif

  modport slave (
    input  pc_in, pc_valid, flush, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, instr_ready,
    output pc_ready, imem_req_valid, imem_req_addr, instr_valid,
           instr_pc, instr_data
`ifdef IFETCH_MISALIGN_CHECK_EN
    , output instr_misalign
`endif
  );

  modport master (
    output pc_in, pc_valid, flush, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, instr_ready,
    input  pc_ready, imem_req_valid, imem_req_addr, instr_valid,
           instr_pc, instr_data
`ifdef IFETCH_MISALIGN_CHECK_EN
    , input instr_misalign
`endif
  );

endinterface

// File: rtl/ifetch_buffer_slot_ring.sv
// Slot storage and alloc/fill/read pointers of the fetch buffer ring.
// Optional macro IFETCH_MISALIGN_CHECK_EN stores a misalign flag per slot.
module ifetch_slot_ring
  import ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned XLEN  = XLEN_DEFAULT,
  localparam int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic [XLEN-1:0] issue_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  input  logic            flush,
  output logic [PW-1:0]   used,
  output logic [PW-1:0]   in_flight,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_data
`ifdef IFETCH_MISALIGN_CHECK_EN
  , output logic          head_misalign
`endif
);

  localparam int unsigned IW = PW - 1;

  logic [PW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] pc_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  slot_flags_t     flags_q[DEPTH];
  slot_flags_t     flags_d[DEPTH];
  logic [IW-1:0]   alloc_idx, fill_idx, rd_idx;

  assign alloc_idx = alloc_ptr_q[IW-1:0];
  assign fill_idx  = fill_ptr_q[IW-1:0];
  assign rd_idx    = rd_ptr_q[IW-1:0];

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_d        = pc_q;
    data_d      = data_q;
    flags_d     = flags_q;
    if (issue) begin
      pc_d[alloc_idx]           = issue_pc;
      flags_d[alloc_idx].filled = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      flags_d[alloc_idx].misalign = |issue_pc[1:0];
`endif
      alloc_ptr_d = alloc_ptr_q + PW'(1);
    end
    if (fill) begin
      data_d[fill_idx]         = fill_data;
      flags_d[fill_idx].filled = 1'b1;
      fill_ptr_d               = fill_ptr_q + PW'(1);
    end
    if (pop) begin
      flags_d[rd_idx].filled = 1'b0;
      rd_ptr_d               = rd_ptr_q + PW'(1);
    end
    // Flush collapses the ring onto alloc_ptr; issue and fill are held off by the caller.
    if (flush) begin
      fill_ptr_d = alloc_ptr_q;
      rd_ptr_d   = alloc_ptr_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        flags_d[i].filled = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        data_q[i]  <= '0;
        flags_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
    end
  end

  assign used        = alloc_ptr_q - rd_ptr_q;
  assign in_flight   = alloc_ptr_q - fill_ptr_q;
  assign head_filled = flags_q[rd_idx].filled;
  assign head_pc     = pc_q[rd_idx];
  assign head_data   = data_q[rd_idx];
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign head_misalign = flags_q[rd_idx].misalign;
`endif

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues PC-unit fetches to imem, buffers words in order.
// Optional macro IFETCH_MISALIGN_CHECK_EN drives bus.instr_misalign.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  ifetch_buffer_if.slave bus
);

  localparam int unsigned    PW  = ptr_width(DEPTH);
  localparam logic [PW:0]    CAP = (PW+1)'(DEPTH);

  logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   used, in_flight;
  logic [PW:0]     committed;
  logic            credit_ok, issue, fill, pop, rsp_drop, head_filled, instr_valid;
  logic [XLEN-1:0] head_pc, head_data;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic            head_misalign;
`endif

  // Killed requests still owed a response hold credit until they return.
  assign committed = {1'b0, used} + {1'b0, drop_cnt_q};
  assign credit_ok = committed < CAP;

  assign bus.imem_req_valid = ~reset & bus.pc_valid & credit_ok & ~bus.flush;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.pc_ready       = ~reset & bus.imem_req_ready & credit_ok & ~bus.flush;
  assign issue              = bus.pc_valid & bus.pc_ready;

  assign rsp_drop    = bus.imem_rsp_valid & (drop_cnt_q != '0);
  assign fill        = bus.imem_rsp_valid & ~rsp_drop & ~bus.flush;
  assign instr_valid = (used != '0) & head_filled;
  assign pop         = instr_valid & bus.instr_ready;

  assign bus.instr_valid = instr_valid;
  assign bus.instr_pc    = head_pc;
  assign bus.instr_data  = head_data;
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign bus.instr_misalign = instr_valid & head_misalign;
`endif

  // A response landing in the flush cycle is dropped whichever count it belongs to.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.flush) begin
      drop_cnt_d = drop_cnt_q + in_flight - PW'(bus.imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifetch_slot_ring #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_ring (
    .clk         (clk),
    .rst         (reset),
    .issue       (issue),
    .issue_pc    (bus.pc_in),
    .fill        (fill),
    .fill_data   (bus.imem_rsp_data),
    .pop         (pop),
    .flush       (bus.flush),
    .used        (used),
    .in_flight   (in_flight),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_data   (head_data)
`ifdef IFETCH_MISALIGN_CHECK_EN
    , .head_misalign (head_misalign)
`endif
  );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: directed scenarios plus randomized traffic
// against an epoch/queue reference model. Honours IFETCH_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_ifetch_buffer;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_buffer_if #(.XLEN(XLEN)) bus ();

  ifetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] pc; bit got; } sb_t;
  typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned rdy; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit mis; int unsigned cyc; } dlv_t;

  sb_t   sb[$];        // current-epoch fetches not yet popped, in program order
  mreq_t memq[$];      // requests accepted by memory awaiting a response
  dlv_t  delivered[$]; // what decode actually received

  int unsigned epoch    = 0;
  int unsigned cyc      = 0;
  int unsigned n_issued = 0;
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;

  bit          p_issue, p_pop, p_rsp, p_flush, p_mis;
  logic [31:0] p_addr, p_pc, p_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: expectations from queue contents, sampled mid-cycle.
  always @(negedge clk) begin
    int unsigned old_cnt;
    bit credit, e_ready, e_rv, e_iv, e_mis;
    old_cnt = 0;
    foreach (memq[i]) if (memq[i].epoch != epoch) old_cnt++;
    credit  = (sb.size() + old_cnt) < DEPTH;
    e_ready = !reset && bus.imem_req_ready && credit && !bus.flush;
    e_rv    = !reset && bus.pc_valid && credit && !bus.flush;
    e_iv    = !reset && (sb.size() > 0) && sb[0].got;
    e_mis   = e_iv && (sb[0].pc[1:0] != 2'b00);
    n_run++;
    if (bus.pc_ready !== e_ready) begin
      n_fail++;
      $display("FAIL pc_ready cyc=%0d got=%b exp=%b", cyc, bus.pc_ready, e_ready);
    end
    n_run++;
    if (bus.imem_req_valid !== e_rv) begin
      n_fail++;
      $display("FAIL imem_req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, e_rv);
    end
    if (e_rv) begin
      n_run++;
      if (bus.imem_req_addr !== bus.pc_in) begin
        n_fail++;
        $display("FAIL imem_req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, bus.pc_in);
      end
    end
    n_run++;
    if (bus.instr_valid !== e_iv) begin
      n_fail++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, bus.instr_valid, e_iv);
    end
    if (e_iv) begin
      n_run++;
      if (bus.instr_pc !== sb[0].pc || bus.instr_data !== mem_word(sb[0].pc)) begin
        n_fail++;
        $display("FAIL instr_pair cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.instr_pc,
                 bus.instr_data, sb[0].pc, mem_word(sb[0].pc));
      end
    end
`ifdef IFETCH_MISALIGN_CHECK_EN
    n_run++;
    if (bus.instr_misalign !== e_mis) begin
      n_fail++;
      $display("FAIL instr_misalign cyc=%0d got=%b exp=%b", cyc, bus.instr_misalign, e_mis);
    end
    p_mis = bus.instr_misalign;
`else
    p_mis = e_mis;
`endif
    p_issue = e_rv && bus.imem_req_ready;
    p_addr  = bus.pc_in;
    p_pop   = e_iv && bus.instr_ready;
    p_pc    = bus.instr_pc;
    p_data  = bus.instr_data;
    p_rsp   = !reset && bus.imem_rsp_valid;
    p_flush = !reset && bus.flush;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.delete();
      memq.delete();
      {p_issue, p_pop, p_rsp, p_flush} = '0;
    end else begin
      if (p_pop) begin
        delivered.push_back('{p_pc, p_data, p_mis, cyc});
        void'(sb.pop_front());
      end
      if (p_rsp && memq.size() > 0) begin
        mreq_t m;
        m = memq.pop_front();
        if (m.epoch == epoch && !p_flush) begin
          foreach (sb[i]) if (!sb[i].got) begin sb[i].got = 1'b1; break; end
        end
      end
      if (p_flush) begin
        sb.delete();
        epoch++;
      end
      if (p_issue) begin
        memq.push_back('{p_addr, epoch, cyc + $urandom_range(lat_max, lat_min)});
        sb.push_back('{p_addr, 1'b0});
        n_issued++;
      end
      cyc++;
    end
  end

  // In-order memory: presents the oldest request once its latency has elapsed.
  always @(posedge clk) begin
    #1;
    if (!reset && memq.size() > 0 && memq[0].rdy <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bus.pc_valid = 1'b0; bus.flush = 1'b0;
    bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    bus.pc_valid = 1'b1; bus.imem_req_ready = 1'b1; bus.pc_in = 32'h100;
    #1;
    n_run++;
    if (bus.pc_ready !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b req=%b iv=%b exp 0/0/0",
               bus.pc_ready, bus.imem_req_valid, bus.instr_valid);
    end
    bus.pc_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    delivered.delete(); lat_min = 1; lat_max = 1;
    bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.pc_valid = 1'b1; bus.pc_in = 32'(k * 4); tick();
    end
    bus.pc_valid = 1'b0;
    repeat (5) tick();
    n_run++;
    if (delivered.size() != 3) begin
      n_fail++; $display("FAIL seq_count got=%0d exp=3", delivered.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if (delivered[k].pc !== 32'(k * 4) || delivered[k].data !== mem_word(32'(k * 4))) begin
          n_fail++;
          $display("FAIL seq_word%0d got=%h/%h exp=%h/%h", k, delivered[k].pc,
                   delivered[k].data, k * 4, mem_word(32'(k * 4)));
        end
        if (k > 0) begin
          n_run++;
          if (delivered[k].cyc - delivered[k-1].cyc != 1) begin
            n_fail++;
            $display("FAIL seq_bubble%0d got gap=%0d exp=1", k, delivered[k].cyc - delivered[k-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int unsigned base;
    delivered.delete(); lat_min = 1; lat_max = 1;
    bus.instr_ready = 1'b0; bus.imem_req_ready = 1'b1;
    base = n_issued;
    repeat (8) begin
      bus.pc_valid = (n_issued - base) < 6;
      bus.pc_in = 32'h200 + 4 * (n_issued - base);
      tick();
    end
    n_run++;
    if (n_issued - base != DEPTH || bus.pc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall got issued=%0d rdy=%b exp %0d/0", n_issued - base, bus.pc_ready, DEPTH);
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20 && (n_issued - base) < 6; i++) begin
      bus.pc_valid = 1'b1;
      bus.pc_in = 32'h200 + 4 * (n_issued - base);
      tick();
    end
    bus.pc_valid = 1'b0;
    repeat (8) tick();
    n_run++;
    if (n_issued - base != 6 || delivered.size() != 6) begin
      n_fail++;
      $display("FAIL bp_resume got issued=%0d delivered=%0d exp 6/6", n_issued - base, delivered.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_run++;
        if (delivered[k].pc !== 32'h200 + 32'(4 * k)) begin
          n_fail++;
          $display("FAIL bp_order%0d got=%h exp=%h", k, delivered[k].pc, 32'h200 + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_flush_inflight();
    delivered.delete(); lat_min = 3; lat_max = 3;
    bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
    bus.pc_valid = 1'b1; bus.pc_in = 32'h10; tick();
    bus.pc_in = 32'h14; tick();
    bus.flush = 1'b1; bus.pc_in = 32'h99;
    #1;
    n_run++;
    if (bus.imem_req_valid !== 1'b0 || bus.pc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_issue got req=%b rdy=%b exp 0/0", bus.imem_req_valid, bus.pc_ready);
    end
    tick();
    bus.flush = 1'b0; bus.pc_in = 32'h40;
    #1;
    n_run++;
    if (bus.pc_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_credit got rdy=%b exp 1", bus.pc_ready);
    end
    tick();
    bus.pc_valid = 1'b0;
    repeat (8) tick();
    n_run++;
    if (delivered.size() != 1 || delivered[0].pc !== 32'h40 || delivered[0].data !== mem_word(32'h40)) begin
      n_fail++;
      $display("FAIL flush_deliver got n=%0d pc=%h data=%h exp 1/00000040/%h", delivered.size(),
               delivered.size() ? delivered[0].pc : 32'hx, delivered.size() ? delivered[0].data : 32'hx,
               mem_word(32'h40));
    end
  endtask

  task automatic test_flush_coincident();
    delivered.delete(); lat_min = 2; lat_max = 2;
    bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
    bus.pc_valid = 1'b1; bus.pc_in = 32'h20; tick();
    bus.pc_in = 32'h24; tick();
    bus.pc_valid = 1'b0; bus.flush = 1'b1; tick();
    bus.flush = 1'b0; bus.pc_valid = 1'b1; bus.pc_in = 32'h60; tick();
    bus.pc_valid = 1'b0;
    repeat (6) tick();
    n_run++;
    if (delivered.size() != 1 || delivered[0].pc !== 32'h60 || delivered[0].data !== mem_word(32'h60)) begin
      n_fail++;
      $display("FAIL coinc_deliver got n=%0d pc=%h data=%h exp 1/00000060/%h", delivered.size(),
               delivered.size() ? delivered[0].pc : 32'hx, delivered.size() ? delivered[0].data : 32'hx,
               mem_word(32'h60));
    end
  endtask

  task automatic test_reset_mid();
    delivered.delete(); lat_min = 1; lat_max = 1;
    bus.instr_ready = 1'b0; bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.pc_valid = 1'b1; bus.pc_in = 32'h300 + 32'(4 * k); tick();
    end
    bus.pc_valid = 1'b0;
    repeat (2) tick();
    n_run++;
    if (bus.instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre got iv=%b exp 1", bus.instr_valid);
    end
    #2;
    reset = 1'b1; bus.pc_valid = 1'b1;
    #1;
    n_run++;
    if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got iv=%b rdy=%b req=%b exp 0/0/0",
               bus.instr_valid, bus.pc_ready, bus.imem_req_valid);
    end
    bus.pc_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    tick();
    bus.instr_ready = 1'b1; bus.pc_valid = 1'b1; bus.pc_in = 32'h0; tick();
    bus.pc_valid = 1'b0;
    repeat (4) tick();
    n_run++;
    if (delivered.size() != 1 || delivered[0].pc !== 32'h0 || delivered[0].data !== mem_word(32'h0)) begin
      n_fail++;
      $display("FAIL rstmid_post got n=%0d exp 1 word at pc 0", delivered.size());
    end
  endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    delivered.delete(); lat_min = 1; lat_max = 1;
    bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
    bus.pc_valid = 1'b1; bus.pc_in = 32'h102; tick();
    bus.pc_in = 32'h104; tick();
    bus.pc_valid = 1'b0;
    repeat (5) tick();
    n_run++;
    if (delivered.size() != 2 || delivered[0].pc !== 32'h102 || delivered[0].mis !== 1'b1
        || delivered[1].pc !== 32'h104 || delivered[1].mis !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign got n=%0d exp 2 words 102/mis=1 104/mis=0", delivered.size());
    end
  endtask
`endif

  task automatic test_random();
    lat_min = 1; lat_max = 4;
    repeat (800) begin
      bus.pc_valid       = $urandom_range(0, 3) != 0;
      bus.pc_in          = $urandom;
      bus.imem_req_ready = $urandom_range(0, 3) != 0;
      bus.instr_ready    = $urandom_range(0, 2) != 0;
      bus.flush          = $urandom_range(0, 15) == 0;
      tick();
    end
    idle(30);
    n_run++;
    if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_drain got iv=%b rdy=%b exp 0/1", bus.instr_valid, bus.pc_ready);
    end
  endtask

  initial begin
    bus.pc_valid = 1'b0; bus.pc_in = '0; bus.flush = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_sequential();      idle(4);
    test_back_pressure();   idle(4);
    test_flush_inflight();  idle(4);
    test_flush_coincident(); idle(4);
    test_reset_mid();       idle(4);
`ifdef IFETCH_MISALIGN_CHECK_EN
    test_misalign();        idle(4);
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
